// File: rtl/param_sync_fifo_if.sv
// -----------------------------------------------------------------------------
// param_sync_fifo_if
// Bundles the write, read, status and error signals of one param_sync_fifo
// instance. clk and rst are not part of the bundle; they stay plain ports.
//
// Parameters
//   DATA_WIDTH  word width in bits
//   DEPTH       FIFO depth in words; sets the width of level
//
// Signals
//   wr_en, wr_data   write request and word          (master -> slave)
//   rd_en            pop request                     (master -> slave)
//   err_clr          clears sticky error flags       (master -> slave)
//   rd_data          read word                       (slave -> master)
//   rd_valid         rd_data holds a popped/head word (slave -> master)
//   full, empty      level == DEPTH / level == 0      (slave -> master)
//   almost_full      level >= AF_THRESH               (slave -> master)
//   almost_empty     level <= AE_THRESH               (slave -> master)
//   level            word count, 0..DEPTH             (slave -> master)
//   overflow         sticky: write while full         (slave -> master)
//   underflow        sticky: read while empty         (slave -> master)
//
// Modports
//   master  the framer / arbiter side that drives requests
//   slave   the FIFO itself
// -----------------------------------------------------------------------------
interface param_sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 106
);
  localparam int LW = $clog2(DEPTH + 1);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [LW-1:0]         level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, err_clr,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/param_sync_fifo.sv
// -----------------------------------------------------------------------------
// param_sync_fifo
// Single-clock FIFO for ATM cell buffering between an input-port framer and
// the switch fabric arbiter. Any depth >= 2 is supported: both pointers wrap
// explicitly from DEPTH-1 to 0, so no power-of-2 rollover is assumed. It
// provides a word count, programmable almost-full/almost-empty flags and
// sticky overflow/underflow error flags.
//
// Parameters
//   DATA_WIDTH  word width (>=1)
//   DEPTH       number of words (>=2)
//   AF_THRESH   almost_full when level >= AF_THRESH (1..DEPTH)
//   AE_THRESH   almost_empty when level <= AE_THRESH (0..DEPTH-1)
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous reset, active-high. It empties the FIFO, clears the
//         error flags and rd_data/rd_valid. Memory contents are kept.
//   bus   param_sync_fifo_if.slave. It carries the write/read requests,
//         data, status flags, level and error flags.
//
// Build option
//   PARAM_SYNC_FIFO_FWFT_EN  first-word-fall-through. rd_data shows the head
//                            word combinationally and rd_valid = !empty. When
//                            the macro is undefined, reads have a registered
//                            1-cycle latency.
// -----------------------------------------------------------------------------
module param_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 106,
  parameter int AF_THRESH  = 53,
  parameter int AE_THRESH  = 0
) (
  input logic              clk,
  input logic              rst,
  param_sync_fifo_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AF_THRESH);
  localparam logic [LW-1:0] LVL_AE   = LW'(AE_THRESH);

  // Stop elaboration on parameter combinations the FIFO cannot honour.
  if (DEPTH < 2) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("param_sync_fifo: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("param_sync_fifo: AE_THRESH must be in 0..DEPTH-1");
  end

  // A pointer at the last slot returns to 0, so it does not run on to the
  // next binary value.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    logic [AW-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = {AW{1'b0}};
    end else begin
      nxt = ptr + AW'(1);
    end
    return nxt;
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [LW-1:0]         level_r;
  logic [LW-1:0]         level_nxt_s;
  logic                  full_r;
  logic                  empty_r;
  logic                  almost_full_r;
  logic                  almost_empty_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic                  ovf_set_s;
  logic                  unf_set_s;

  // Decide which requests are accepted, find the next level and detect error
  // events. Both use the flags as they stand at the start of the cycle.
  always_comb begin
    wr_acc_s  = bus.wr_en && !full_r;
    rd_acc_s  = bus.rd_en && !empty_r;
    // A request met by an opposite request in the same cycle is treated as
    // flow-through, so it does not count as an error.
    ovf_set_s = bus.wr_en && full_r  && !bus.rd_en;
    unf_set_s = bus.rd_en && empty_r && !bus.wr_en;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Pointers, level and status flags. The flags are registered from the next
  // level, so they always match a decode of level_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r       <= {AW{1'b0}};
      rd_ptr_r       <= {AW{1'b0}};
      level_r        <= {LW{1'b0}};
      full_r         <= 1'b0;
      empty_r        <= 1'b1;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (rd_acc_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      level_r        <= level_nxt_s;
      full_r         <= (level_nxt_s == LVL_FULL);
      empty_r        <= (level_nxt_s == {LW{1'b0}});
      almost_full_r  <= (level_nxt_s >= LVL_AF);
      almost_empty_r <= (level_nxt_s <= LVL_AE);
    end
  end

  // Sticky error flags. A new error event wins over err_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (bus.err_clr) begin
        overflow_r <= 1'b0;
      end
      if (unf_set_s) begin
        underflow_r <= 1'b1;
      end else if (bus.err_clr) begin
        underflow_r <= 1'b0;
      end
    end
  end

  // Storage array. It has no reset, and writes are ignored while rst is high.
  always_ff @(posedge clk) begin
    if (wr_acc_s && !rst) begin
      mem_r[wr_ptr_r] <= bus.wr_data;
    end
  end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  // Head word is always on rd_data. rd_en only advances rd_ptr_r.
  always_comb begin
    bus.rd_data  = mem_r[rd_ptr_r];
    bus.rd_valid = !empty_r;
  end
`else
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_valid_r;

  // Registered read port. rd_valid pulses for exactly one cycle per accepted
  // read, and rd_data keeps the last popped word until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r  <= {DATA_WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_acc_s;
      if (rd_acc_s) begin
        rd_data_r <= mem_r[rd_ptr_r];
      end
    end
  end

  assign bus.rd_data  = rd_data_r;
  assign bus.rd_valid = rd_valid_r;
`endif

  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.almost_full  = almost_full_r;
  assign bus.almost_empty = almost_empty_r;
  assign bus.level        = level_r;
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;

endmodule

// File: tb/tb_param_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_param_sync_fifo
// Directed bench for param_sync_fifo with DEPTH=106, AF_THRESH=53 and
// AE_THRESH=2. A queue-based model holds the stored words, the error flags and
// the expected read port. One process compares every DUT output against it on
// each falling edge. Literal checks at key points tie the model to known
// values. Build with PARAM_SYNC_FIFO_FWFT_EN defined to exercise the
// first-word-fall-through read port.
// -----------------------------------------------------------------------------
module tb_param_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 106;
  localparam int AF    = 53;
  localparam int AE    = 2;

  logic clk;
  logic rst;

  param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  param_sync_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state
  logic [DW-1:0] q[$];
  logic          m_ovf      = 1'b0;
  logic          m_unf      = 1'b0;
  logic          m_rd_valid = 1'b0;
  logic [DW-1:0] m_rd_data  = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive the inputs, update the model at the rising edge, then
  // return at the falling edge.
  task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd,
                      input logic clr, input logic r);
    int sz;
    bit wa;
    bit ra;
    bus.wr_en   = wr;
    bus.wr_data = d;
    bus.rd_en   = rd;
    bus.err_clr = clr;
    rst         = r;
    @(posedge clk);
    sz = q.size();
    if (r) begin
      q.delete();
      m_ovf      = 1'b0;
      m_unf      = 1'b0;
      m_rd_valid = 1'b0;
      m_rd_data  = '0;
    end else begin
      wa = wr && (sz < DEPTH);
      ra = rd && (sz > 0);
      if (wr && sz == DEPTH && !rd) m_ovf = 1'b1;
      else if (clr)                 m_ovf = 1'b0;
      if (rd && sz == 0 && !wr)     m_unf = 1'b1;
      else if (clr)                 m_unf = 1'b0;
      m_rd_valid = ra;
      if (ra) m_rd_data = q.pop_front();
      if (wa) q.push_back(d);
    end
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) step(1'b1, DW'(base + i), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  // Compare every DUT output with the model once per cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("level",        32'(bus.level),        32'(q.size()));
      check("full",         32'(bus.full),         32'(q.size() == DEPTH));
      check("empty",        32'(bus.empty),        32'(q.size() == 0));
      check("almost_full",  32'(bus.almost_full),  32'(q.size() >= AF));
      check("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= AE));
      check("overflow",     32'(bus.overflow),     32'(m_ovf));
      check("underflow",    32'(bus.underflow),    32'(m_unf));
`ifdef PARAM_SYNC_FIFO_FWFT_EN
      check("rd_valid",     32'(bus.rd_valid),     32'(q.size() != 0));
      if (q.size() != 0) check("rd_data", 32'(bus.rd_data), 32'(q[0]));
`else
      check("rd_valid",     32'(bus.rd_valid),     32'(m_rd_valid));
      check("rd_data",      32'(bus.rd_data),      32'(m_rd_data));
`endif
    end
  end

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
    rst         = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("rst_level",    32'(bus.level),        32'd0);
    check("rst_empty",    32'(bus.empty),        32'd1);
    check("rst_ae",       32'(bus.almost_empty), 32'd1);
    check("rst_af",       32'(bus.almost_full),  32'd0);
    check("rst_full",     32'(bus.full),         32'd0);

    // T1: reset mid-fill, with a write in the reset cycle that is ignored
    push_n(10, 8'h10);
    check("t1_level10",   32'(bus.level),        32'd10);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    check("t1_level0",    32'(bus.level),        32'd0);
    check("t1_empty",     32'(bus.empty),        32'd1);
    check("t1_rd_valid",  32'(bus.rd_valid),     32'd0);
    check("t1_overflow",  32'(bus.overflow),     32'd0);

    // T2: fill/drain twice; the second pass starts at slot 1 so both pointers wrap
    push_n(DEPTH, 8'h00);
    check("t2_full",      32'(bus.full),         32'd1);
    check("t2_level",     32'(bus.level),        32'd106);
    pop_n(1);
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    check("t2_first",     32'(bus.rd_data),      32'h00);
`endif
    pop_n(DEPTH - 1);
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    check("t2_last",      32'(bus.rd_data),      32'h69);
`endif
    check("t2_empty",     32'(bus.empty),        32'd1);
    push_n(1, 8'hEE);
    pop_n(1);
    push_n(DEPTH, 8'h00);
    check("t2b_full",     32'(bus.full),         32'd1);
    pop_n(DEPTH);
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    check("t2b_last",     32'(bus.rd_data),      32'h69);
`endif
    check("t2b_empty",    32'(bus.empty),        32'd1);

    // T3: threshold edges
    push_n(52, 8'h40);
    check("t3_af_52",     32'(bus.almost_full),  32'd0);
    push_n(1, 8'h74);
    check("t3_af_53",     32'(bus.almost_full),  32'd1);
    pop_n(50);
    check("t3_ae_3",      32'(bus.almost_empty), 32'd0);
    pop_n(1);
    check("t3_ae_2",      32'(bus.almost_empty), 32'd1);
    pop_n(2);

    // T5: error flags
    push_n(DEPTH, 8'h80);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    check("t5_ovf",       32'(bus.overflow),     32'd1);
    check("t5_lvl",       32'(bus.level),        32'd106);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("t5_ovf_clr",   32'(bus.overflow),     32'd0);
    pop_n(DEPTH);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("t5_unf",       32'(bus.underflow),    32'd1);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("t5_set_prio",  32'(bus.underflow),    32'd1);

    // T4: simultaneous write and read at empty, full and mid level
    step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    check("t4_empty_lvl", 32'(bus.level),        32'd1);
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    check("t4_empty_rv",  32'(bus.rd_valid),     32'd0);
`endif
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    push_n(DEPTH - 1, 8'h00);
    step(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
    check("t4_full_lvl",  32'(bus.level),        32'd105);
    check("t4_full_ovf",  32'(bus.overflow),     32'd0);
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    check("t4_full_data", 32'(bus.rd_data),      32'h3C);
`endif
    pop_n(55);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, DW'(8'hD0 + i), 1'b1, 1'b0, 1'b0);
      check("t4_mid_lvl", 32'(bus.level),        32'd50);
    end
    pop_n(50);
    check("t4_drained",   32'(bus.empty),        32'd1);

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    // T6: head word falls through without rd_en
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("t6_valid",     32'(bus.rd_valid),     32'd1);
    check("t6_data",      32'(bus.rd_data),      32'hA5);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("t6_empty",     32'(bus.empty),        32'd1);
    check("t6_novalid",   32'(bus.rd_valid),     32'd0);
`endif

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
